// File: rtl/positadd_es2_arbiter.sv
// -----------------------------------------------------------------------------
// positadd_es2_arbiter
//
// Round-robin arbiter that lets NREQ requesters share one pipelined ES2 posit
// adder core. The core has a fixed start-to-done latency, never stalls and has
// no reset. At most one add is issued per cycle. A tag shift register that
// runs in step with the core records which requester owns each in-flight op,
// and each result is steered back to that requester.
//
// Parameters
//   NREQ                           number of requesters (2..16)
//   LATENCY                        adder core start-to-done latency, cycles
//   POSIT_SERIALIZED_WIDTH_ES2     width of one serialized ES2 operand
//   POSIT_SERIALIZED_WIDTH_SUM_ES2 width of the serialized ES2 sum
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   req_valid        per-requester operand valid
//   req_ready        per-requester accept, one-hot or zero
//   req_in1/req_in2  packed operands, requester i in slice i
//   rsp_valid        one-hot result strobe to the owning requester
//   rsp_result       shared result bus, qualified by rsp_valid
//   rsp_truncated    truncation flag, qualified by rsp_valid
//   pause            blocks new grants; in-flight ops still complete
//   add_in1/add_in2  operands to the adder core
//   add_start        issue strobe to the adder core
//   add_result       adder core result
//   add_done         adder core done strobe
//   add_truncated    adder core truncation flag
//   busy             drain active, op in flight or response pending
//   err_seq          sticky: add_done disagreed with the expected tag
// -----------------------------------------------------------------------------
module positadd_es2_arbiter #(
  parameter int NREQ                           = 4,
  parameter int LATENCY                        = 8,
  parameter int POSIT_SERIALIZED_WIDTH_ES2     = 38,
  parameter int POSIT_SERIALIZED_WIDTH_SUM_ES2 = 39
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NREQ-1:0]                            req_valid,
  output logic [NREQ-1:0]                            req_ready,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES2-1:0] req_in1,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES2-1:0] req_in2,
  output logic [NREQ-1:0]                            rsp_valid,
  output logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]  rsp_result,
  output logic                                       rsp_truncated,
  input  logic                                       pause,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]      add_in1,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0]      add_in2,
  output logic                                       add_start,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES2-1:0]  add_result,
  input  logic                                       add_done,
  input  logic                                       add_truncated,
  output logic                                       busy,
  output logic                                       err_seq
);

  // Requester-ID width is derived from NREQ and is not meant to be overridden.
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = POSIT_SERIALIZED_WIDTH_ES2;
  localparam int DW  = $clog2(LATENCY + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]  rr_ptr;      // last granted requester
  logic [DW-1:0]   drain_cnt;   // cycles left to absorb pre-reset core traffic
  logic [IDW-1:0]  issue_id;    // owner of the op currently on add_start

  // Tag pipeline: stage s holds the owner of the op started s+1 cycles ago,
  // so the last stage lines up with add_done of the same op.
  logic [LATENCY-1:0] tag_valid;
  logic [IDW-1:0]     tag_id [LATENCY];

  logic               tag_out_valid;
  logic [IDW-1:0]     tag_out_id;
  logic               drain_active;

  assign tag_out_valid = tag_valid[LATENCY-1];
  assign tag_out_id    = tag_id[LATENCY-1];
  assign drain_active  = (drain_cnt != '0);

  // ---------------------------------------------------------------------------
  // Round-robin grant search, starting just after the last granted requester.
  // ---------------------------------------------------------------------------
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           grant_ok;
  logic           accept;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Reset is folded in so req_ready is low while reset is asserted, not just
  // from the edge that loads the drain counter.
  assign grant_ok = grant_found && !pause && !drain_active && !reset;

  always_comb begin
    req_ready = '0;
    if (grant_ok) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // The grant only ever points at a valid requester, so a non-zero ready is
  // always an accept.
  assign accept = |(req_valid & req_ready);

  // ---------------------------------------------------------------------------
  // Control state: pointer, drain counter, issue strobe, operands, tag valids,
  // response strobe and the sequence error flag.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours, which is what makes
  // the tag shift register shift by exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= IDW'(NREQ - 1);
      drain_cnt     <= DW'(LATENCY);
      add_start     <= 1'b0;
      add_in1       <= '0;
      add_in2       <= '0;
      issue_id      <= '0;
      tag_valid     <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_truncated <= 1'b0;
      err_seq       <= 1'b0;
    end else begin
      if (drain_active) begin
        drain_cnt <= drain_cnt - 1'b1;
      end

      // Issue stage: operands hold their last values when nothing is accepted.
      add_start <= accept;
      if (accept) begin
        rr_ptr   <= grant_id;
        issue_id <= grant_id;
        add_in1  <= req_in1[int'(grant_id)*PW +: PW];
        add_in2  <= req_in2[int'(grant_id)*PW +: PW];
      end

      tag_valid[0] <= add_start;
      for (int s = 1; s < LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
      end

      // Results are qualified by our own tag, never by add_done alone, so a
      // spurious done pulse cannot reach a requester.
      if (tag_out_valid) begin
        rsp_valid     <= '0;
        rsp_valid[tag_out_id] <= 1'b1;
        rsp_result    <= add_result;
        rsp_truncated <= add_truncated;
      end else begin
        rsp_valid <= '0;
      end

      // While draining, done pulses from ops started before reset are expected
      // and carry no tag, so the comparison is masked.
      if (!drain_active && (add_done != tag_out_valid)) begin
        err_seq <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag IDs. Only meaningful where the matching tag_valid bit is set.
  // ---------------------------------------------------------------------------
  // NOTE: the ID array is deliberately left without reset; the valid bits are
  // reset and gate every use, so clearing the IDs would only add reset fan-out.
  always_ff @(posedge clk) begin
    tag_id[0] <= issue_id;
    for (int s = 1; s < LATENCY; s++) begin
      tag_id[s] <= tag_id[s-1];
    end
  end

  assign busy = drain_active | add_start | (|tag_valid) | (|rsp_valid);

endmodule

// File: tb/tb_positadd_es2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_positadd_es2_arbiter
//
// Directed bench for positadd_es2_arbiter. A small behavioural stand-in for the
// adder core (fixed latency, no reset, result = in1 + in2, truncated = MSB of
// in1) drives add_done/add_result. Each accept is entered in a per-cycle
// expectation table LATENCY+2 cycles ahead; a negedge monitor compares the
// response outputs against it, and directed checks cover grants, issue,
// drain, pause, reset with ops in flight, err_seq and truncation.
// -----------------------------------------------------------------------------
module tb_positadd_es2_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 8;
  localparam int W    = 38;
  localparam int SW   = 39;
  localparam int SB   = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_in1;
  logic [NREQ*W-1:0] req_in2;
  logic [NREQ-1:0]   rsp_valid;
  logic [SW-1:0]     rsp_result;
  logic              rsp_truncated;
  logic              pause;
  logic [W-1:0]      add_in1;
  logic [W-1:0]      add_in2;
  logic              add_start;
  logic [SW-1:0]     add_result;
  logic              add_done;
  logic              add_truncated;
  logic              busy;
  logic              err_seq;

  positadd_es2_arbiter #(
    .NREQ                          (NREQ),
    .LATENCY                       (LAT),
    .POSIT_SERIALIZED_WIDTH_ES2    (W),
    .POSIT_SERIALIZED_WIDTH_SUM_ES2(SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_in1      (req_in1),
    .req_in2      (req_in2),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_truncated(rsp_truncated),
    .pause        (pause),
    .add_in1      (add_in1),
    .add_in2      (add_in2),
    .add_start    (add_start),
    .add_result   (add_result),
    .add_done     (add_done),
    .add_truncated(add_truncated),
    .busy         (busy),
    .err_seq      (err_seq)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Operand storage per requester
  // ---------------------------------------------------------------------------
  logic [W-1:0] op_a [NREQ];
  logic [W-1:0] op_b [NREQ];

  always_comb begin
    req_in1 = '0;
    req_in2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*W +: W] = op_a[i];
      req_in2[i*W +: W] = op_b[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Adder core stand-in: no reset, start-to-done latency LAT.
  // ---------------------------------------------------------------------------
  logic          core_v [LAT];
  logic [SW-1:0] core_r [LAT];
  logic          core_t [LAT];
  logic          force_done;

  initial begin
    for (int j = 0; j < LAT; j++) begin
      core_v[j] = 1'b0;
      core_r[j] = '0;
      core_t[j] = 1'b0;
    end
  end

  always @(posedge clk) begin
    core_v[0] <= add_start;
    core_r[0] <= {1'b0, add_in1} + {1'b0, add_in2};
    core_t[0] <= add_in1[W-1];
    for (int j = 1; j < LAT; j++) begin
      core_v[j] <= core_v[j-1];
      core_r[j] <= core_r[j-1];
      core_t[j] <= core_t[j-1];
    end
  end

  assign add_done      = core_v[LAT-1] | force_done;
  assign add_result    = core_r[LAT-1];
  assign add_truncated = core_t[LAT-1];

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rsp_seen = 0;
  logic mon_en = 1'b0;

  logic [NREQ-1:0] exp_v [SB];
  logic [SW-1:0]   exp_r [SB];
  logic            exp_t [SB];

  initial begin
    for (int c = 0; c < SB; c++) begin
      exp_v[c] = '0;
      exp_r[c] = '0;
      exp_t[c] = 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Response monitor against the expectation table.
  always @(negedge clk) begin
    if (mon_en && cyc < SB) begin
      if (rsp_valid != '0 || exp_v[cyc] != '0) begin
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v[cyc]));
        if (exp_v[cyc] != '0) begin
          check("rsp_result", 64'(rsp_result), 64'(exp_r[cyc]));
          check("rsp_truncated", 64'(rsp_truncated), 64'(exp_t[cyc]));
        end
      end
      if (rsp_valid != '0) rsp_seen++;
    end
  end

  task automatic settle();
    #1;
  endtask

  // Record any accept in the current cycle, then move to the next negedge.
  task automatic step();
    settle();
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i] && (cyc + LAT + 2 < SB)) begin
        exp_v[cyc + LAT + 2][i] = 1'b1;
        exp_r[cyc + LAT + 2]    = {1'b0, op_a[i]} + {1'b0, op_b[i]};
        exp_t[cyc + LAT + 2]    = op_a[i][W-1];
      end
    end
    @(negedge clk);
  endtask

  // One-cycle reset pulse; nothing in flight may answer after it.
  task automatic do_reset();
    reset = 1'b1;
    for (int c = cyc + 1; c < SB; c++) exp_v[c] = '0;
    @(negedge clk);
    settle();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_result", 64'(rsp_result), 64'(0));
    check("rst_rsp_trunc", 64'(rsp_truncated), 64'(0));
    check("rst_add_start", 64'(add_start), 64'(0));
    check("rst_add_in1", 64'(add_in1), 64'(0));
    check("rst_add_in2", 64'(add_in2), 64'(0));
    check("rst_err_seq", 64'(err_seq), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    reset = 1'b0;
  endtask

  // Watchdog: the stimulus has no open-ended waits, this only guards a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [W-1:0]  OP_ONE  = 38'h00_0010_0000;
  localparam logic [SW-1:0] SUM_ONE = 39'h00_0020_0000;
  localparam logic [W-1:0]  OP_BIG  = 38'h20_0000_0000;
  localparam logic [W-1:0]  OP_TINY = 38'h00_0000_0100;
  localparam logic [SW-1:0] SUM_BIG = 39'h20_0000_0100;

  int seen0;

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    pause      = 1'b0;
    force_done = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // --- 1: drain after reset, single op from requester 0 -------------------
    do_reset();
    mon_en    = 1'b1;
    op_a[0]   = OP_ONE;
    op_b[0]   = OP_ONE;
    req_valid = 4'b0001;
    for (int k = 0; k < LAT; k++) begin
      settle();
      check("t1_drain_ready", 64'(req_ready), 64'(0));
      check("t1_drain_busy", 64'(busy), 64'(1));
      step();
    end
    settle();
    check("t1_ready", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    settle();
    check("t1_add_start", 64'(add_start), 64'(1));
    check("t1_add_in1", 64'(add_in1), 64'(OP_ONE));
    check("t1_add_in2", 64'(add_in2), 64'(OP_ONE));
    step();
    repeat (LAT - 1) step();
    check("t1_rsp_early", 64'(rsp_valid), 64'(0));
    step();
    check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("t1_rsp_result", 64'(rsp_result), 64'(SUM_ONE));
    step();
    check("t1_rsp_one_cycle", 64'(rsp_valid), 64'(0));

    // --- 2: all four requesters continuously valid --------------------------
    do_reset();
    repeat (LAT) step();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = W'(i << 12);
      op_b[i] = W'(8'h55 * (i + 1));
    end
    seen0     = rsp_seen;
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      settle();
      check("t2_grant", 64'(req_ready), 64'(4'b0001 << (k % NREQ)));
      if (k > 0) check("t2_add_start", 64'(add_start), 64'(1));
      step();
      op_a[k % NREQ] = op_a[k % NREQ] + 1'b1;
    end
    req_valid = '0;
    settle();
    check("t2_add_start_last", 64'(add_start), 64'(1));
    repeat (LAT + 3) step();
    check("t2_rsp_count", 64'(rsp_seen - seen0), 64'(12));
    check("t2_idle", 64'(busy), 64'(0));

    // --- 3: requester 2 alone with pause toggling ---------------------------
    seen0     = rsp_seen;
    op_a[2]   = 38'h00_0000_1234;
    op_b[2]   = 38'h00_0000_0011;
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      pause = (k % 2 == 0);
      settle();
      check("t3_ready", 64'(req_ready), (k % 2 == 0) ? 64'(0) : 64'(4'b0100));
      step();
      if (k % 2 == 1) op_a[2] = op_a[2] + 38'h100;
    end
    req_valid = '0;
    pause     = 1'b1;
    repeat (LAT + 4) step();
    check("t3_rsp_under_pause", 64'(rsp_seen - seen0), 64'(2));
    pause = 1'b0;

    // --- 4: reset with two ops in flight ------------------------------------
    seen0     = rsp_seen;
    op_a[1]   = 38'h00_0000_0700;
    op_b[1]   = 38'h00_0000_0007;
    req_valid = 4'b0010;
    settle();
    check("t4_ready_a", 64'(req_ready), 64'(4'b0010));
    step();
    op_a[1] = 38'h00_0000_0800;
    settle();
    check("t4_ready_b", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    step();
    step();
    do_reset();
    repeat (LAT) step();
    settle();
    check("t4_err_after_drain", 64'(err_seq), 64'(0));
    check("t4_idle_after_drain", 64'(busy), 64'(0));
    check("t4_no_stale_rsp", 64'(rsp_seen - seen0), 64'(0));
    op_a[0]   = 38'h00_0000_0abc;
    op_b[0]   = 38'h00_0000_0001;
    req_valid = 4'b0001;
    settle();
    check("t4_ready_new", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    repeat (LAT + 3) step();
    check("t4_new_rsp", 64'(rsp_seen - seen0), 64'(1));
    check("t4_err_final", 64'(err_seq), 64'(0));

    // --- 5: spurious add_done with an empty tag pipeline --------------------
    seen0      = rsp_seen;
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    settle();
    check("t5_err_set", 64'(err_seq), 64'(1));
    repeat (5) step();
    check("t5_err_sticky", 64'(err_seq), 64'(1));
    check("t5_no_rsp", 64'(rsp_seen - seen0), 64'(0));
    do_reset();
    settle();
    check("t5_err_cleared", 64'(err_seq), 64'(0));

    // --- 6: truncated result to requester 3 ---------------------------------
    repeat (LAT) step();
    op_a[3]   = OP_BIG;
    op_b[3]   = OP_TINY;
    req_valid = 4'b1000;
    settle();
    check("t6_ready", 64'(req_ready), 64'(4'b1000));
    step();
    req_valid = '0;
    repeat (LAT + 1) step();
    check("t6_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
    check("t6_rsp_trunc", 64'(rsp_truncated), 64'(1));
    check("t6_rsp_result", 64'(rsp_result), 64'(SUM_BIG));
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
